// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: bus widths,
// arbitration state encoding and MIPS-style kernel segment bases.
package mem_arbiter_pkg;

  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  localparam logic [ADDR_W-1:0] KSEG0_BASE = 32'h8000_0000;
  localparam logic [ADDR_W-1:0] KSEG1_BASE = 32'hA000_0000;
  localparam logic [ADDR_W-1:0] KSEG2_BASE = 32'hC000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INST = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_addr_map.sv
// Virtual-to-physical translation for the fixed kseg0/kseg1 windows;
// kseg1 is the only uncached region.
module mem_addr_map
  import mem_arbiter_pkg::*;
(
  input  logic [ADDR_W-1:0] vaddr,
  output logic [ADDR_W-1:0] paddr,
  output logic              cached
);

  always_comb begin
    paddr  = vaddr;
    cached = 1'b1;
    if (vaddr >= KSEG0_BASE && vaddr < KSEG1_BASE) begin
      paddr = vaddr - KSEG0_BASE;
    end else if (vaddr >= KSEG1_BASE && vaddr < KSEG2_BASE) begin
      paddr  = vaddr - KSEG1_BASE;
      cached = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single memory port: data wins ties unless the
// instruction side has been passed over STARVE_LIMIT times in a row.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ready,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [3:0]        data_be,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_cached,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output arb_state_e        state_dbg
);

  // Handshake: a requester holds req and its fields stable until its ready
  // strobe; ready is a one-cycle pulse in the mem_ack cycle, and mem_* stay
  // stable from the cycle after the grant until mem_ack.
  localparam logic [2:0] LIMIT_C = 3'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [2:0]        starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_cached_q, mem_cached_d;

  logic              grant_inst, grant_data, ack;
  logic [ADDR_W-1:0] sel_addr, map_paddr;
  logic              map_cached;

  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (state_q == ST_IDLE) begin
      if (data_req && !(inst_req && starve_q == LIMIT_C)) grant_data = 1'b1;
      else if (inst_req)                                   grant_inst = 1'b1;
    end
  end

  assign sel_addr = grant_inst ? inst_addr : data_addr;

  mem_addr_map u_map (
    .vaddr  (sel_addr),
    .paddr  (map_paddr),
    .cached (map_cached)
  );

  assign ack = mem_req_q & mem_ack;

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_cached_d = mem_cached_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_inst) begin
          state_d      = ST_INST;
          starve_d     = 3'd0;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_be_d     = 4'hF;
          mem_addr_d   = map_paddr;
          mem_wdata_d  = '0;
          mem_cached_d = map_cached;
        end else if (grant_data) begin
          state_d      = ST_DATA;
          mem_req_d    = 1'b1;
          mem_we_d     = data_we;
          mem_be_d     = data_be;
          mem_addr_d   = map_paddr;
          mem_wdata_d  = data_wdata;
          mem_cached_d = map_cached;
          if (inst_req && starve_q != LIMIT_C) starve_d = starve_q + 3'd1;
        end
      end
      ST_INST, ST_DATA: begin
        if (ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      starve_q     <= 3'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'h0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_cached_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_cached_q <= mem_cached_d;
    end
  end

  assign inst_ready = ack && (state_q == ST_INST);
  assign data_ready = ack && (state_q == ST_DATA);
  assign inst_rdata = inst_ready ? mem_rdata : '0;
  assign data_rdata = data_ready ? mem_rdata : '0;

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_cached = mem_cached_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a transaction-level
// arbitration model, directed translation cases and a mid-transaction reset.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req, data_we, mem_ack;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_be;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic        inst_ready, data_ready, mem_req, mem_we, mem_cached;
  logic [3:0]  mem_be;
  arb_state_e  state_dbg;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ready(data_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_cached(mem_cached), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // {owner(1=inst), cached, we, be[3:0], paddr[31:0], wdata[31:0]}
  logic [70:0] exp_q[$];
  logic [70:0] cur_exp;
  bit          m_free = 1'b1, m_first = 1'b0, m_ack;
  int          m_starve = 0;

  int  mode = 0;          // 0 directed/quiet, 1 random, 2 both re-request always
  int  fixed_lat = -1;
  bit  hold_ack = 1'b0;
  bit  inst_seen = 1'b0, data_seen = 1'b0;
  bit  g_active = 1'b0, g_inst = 1'b0;
  int  g_cnt = 0;
  bit  mem_busy_seen = 1'b0;
  int  mem_wait = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] xlate(input logic [31:0] a);
    if (a < 32'h8000_0000)      return {1'b1, a};
    else if (a < 32'hA000_0000) return {1'b1, a - 32'h8000_0000};
    else if (a < 32'hC000_0000) return {1'b0, a - 32'hA000_0000};
    else                        return {1'b1, a};
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return {1'b0, r[30:0]};
      1:       return 32'h8000_0000 + {3'b0, r[28:0]};
      2:       return 32'hA000_0000 + {3'b0, r[28:0]};
      default: return 32'hC000_0000 + {2'b0, r[29:0]};
    endcase
  endfunction

  // Memory: acks after fixed_lat cycles of mem_req (random 0..3 when negative)
  always @(posedge clk) begin
    #2;
    mem_ack = 1'b0;
    if (rst && mem_req && !hold_ack) begin
      if (!mem_busy_seen) begin
        mem_busy_seen = 1'b1;
        mem_wait = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
      end
      if (mem_wait == 0) begin
        mem_ack = 1'b1;
        mem_rdata = $urandom;
        mem_busy_seen = 1'b0;
      end else begin
        mem_wait--;
      end
    end else if (!mem_req) begin
      mem_busy_seen = 1'b0;
    end
  end

  task automatic drive_inst();
    if (!inst_req && (mode == 2 || $urandom_range(0, 99) < 40)) begin
      inst_req  = 1'b1;
      inst_addr = rand_addr();
    end
  endtask

  task automatic drive_data();
    if (!data_req && (mode == 2 || $urandom_range(0, 99) < 50)) begin
      data_req   = 1'b1;
      data_we    = 1'($urandom_range(0, 1));
      data_be    = 4'($urandom_range(1, 15));
      data_addr  = rand_addr();
      data_wdata = $urandom;
    end
  endtask

  initial begin : drivers
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        if (inst_seen) begin inst_req = 1'b0; inst_seen = 1'b0; end
        if (data_seen) begin data_req = 1'b0; data_seen = 1'b0; end
        if (mode != 0) begin
          drive_inst();
          drive_data();
        end
      end
    end
  end

  // Monitor + reference model: one free/busy memory port, starvation count
  always @(negedge clk) begin
    logic [32:0] x;
    bit          gi, exp_ir, exp_dr;
    if (!rst) begin
      m_free = 1'b1; m_first = 1'b0; m_starve = 0;
      exp_q.delete();
      inst_seen = 1'b0; data_seen = 1'b0;
    end else begin
      m_ack = !m_free && mem_ack;
      check("mem_req", 32'(mem_req), 32'(!m_free));
      if (m_first) begin
        m_first = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL exp_q_underflow: got empty queue, required one entry at %0t", $time);
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      if (!m_free) begin
        check("mem_cached", 32'(mem_cached), 32'(cur_exp[69]));
        check("mem_we",     32'(mem_we),     32'(cur_exp[68]));
        check("mem_be",     32'(mem_be),     32'(cur_exp[67:64]));
        check("mem_addr",   mem_addr,        cur_exp[63:32]);
        if (!cur_exp[70]) check("mem_wdata", mem_wdata, cur_exp[31:0]);
      end
      exp_ir = m_ack && cur_exp[70];
      exp_dr = m_ack && !cur_exp[70];
      check("inst_ready", 32'(inst_ready), 32'(exp_ir));
      check("data_ready", 32'(data_ready), 32'(exp_dr));
      check("inst_rdata", inst_rdata, exp_ir ? mem_rdata : 32'h0);
      if (!(exp_dr && cur_exp[68])) check("data_rdata", data_rdata, exp_dr ? mem_rdata : 32'h0);
      if (inst_ready) inst_seen = 1'b1;
      if (data_ready) data_seen = 1'b1;
      if (g_active && !g_inst) begin
        if (data_ready) g_cnt++;
        if (inst_ready) begin
          g_inst = 1'b1;
          check("starve_grants", 32'(g_cnt), 32'(STARVE_LIMIT_DEF));
        end
      end
      if (m_free) begin
        if (inst_req || data_req) begin
          gi = inst_req && (!data_req || m_starve == STARVE_LIMIT_DEF);
          if (gi) begin
            x = xlate(inst_addr);
            exp_q.push_back({1'b1, x[32], 1'b0, 4'hF, x[31:0], 32'h0});
            m_starve = 0;
          end else begin
            x = xlate(data_addr);
            exp_q.push_back({1'b0, x[32], data_we, data_be, x[31:0], data_wdata});
            if (inst_req && m_starve < STARVE_LIMIT_DEF) m_starve++;
          end
          m_free = 1'b0;
          m_first = 1'b1;
        end
      end else if (m_ack) begin
        m_free = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    check("rst_mem_req",    32'(mem_req),    32'h0);
    check("rst_mem_we",     32'(mem_we),     32'h0);
    check("rst_mem_be",     32'(mem_be),     32'h0);
    check("rst_mem_addr",   mem_addr,        32'h0);
    check("rst_mem_wdata",  mem_wdata,       32'h0);
    check("rst_mem_cached", 32'(mem_cached), 32'h1);
    check("rst_ready",      32'({inst_ready, data_ready}), 32'h0);
    check("rst_rdata",      inst_rdata | data_rdata, 32'h0);
    check("rst_state",      32'(state_dbg),  32'(ST_IDLE));
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic directed(input bit is_inst, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_addr, input logic exp_cached,
                          input logic [3:0] exp_be, input int lat);
    int n;
    @(posedge clk); #2;
    fixed_lat = lat;
    if (is_inst) begin
      inst_addr = addr; inst_req = 1'b1;
    end else begin
      data_we = we; data_be = be; data_addr = addr; data_wdata = wdata; data_req = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    check("dir_mem_req_seen", 32'(mem_req), 32'h1);
    if (mem_req) begin
      check("dir_addr",   mem_addr,        exp_addr);
      check("dir_cached", 32'(mem_cached), 32'(exp_cached));
      check("dir_be",     32'(mem_be),     32'(exp_be));
      check("dir_we",     32'(mem_we),     32'(is_inst ? 1'b0 : we));
      n = 0;
      while (!(is_inst ? inst_ready : data_ready) && n < 20) begin @(negedge clk); n++; end
      check("dir_ready_seen", 32'(is_inst ? inst_ready : data_ready), 32'h1);
      if (lat >= 0) check("dir_latency", 32'(n), 32'(lat));
    end
    n = 0;
    while ((inst_req || data_req) && n < 20) begin @(posedge clk); #3; n++; end
    fixed_lat = -1;
  endtask

  task automatic drain();
    int n;
    mode = 0;
    n = 0;
    while ((inst_req || data_req || mem_req) && n < 100) begin @(posedge clk); #3; n++; end
    check("drain_idle", 32'({inst_req, data_req, mem_req}), 32'h0);
    check("drain_queue_empty", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    rst = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    do_reset();

    directed(1'b0, 1'b0, 4'hF,    32'h8000_0010, 32'h0,         32'h0000_0010, 1'b1, 4'hF,    2);
    directed(1'b1, 1'b0, 4'h0,    32'hBFC0_0000, 32'h0,         32'h1FC0_0000, 1'b0, 4'hF,    1);
    directed(1'b0, 1'b1, 4'b0011, 32'h0000_0100, 32'hCAFE_F00D, 32'h0000_0100, 1'b1, 4'b0011, 0);
    directed(1'b0, 1'b0, 4'hF,    32'hC000_1234, 32'h0,         32'hC000_1234, 1'b1, 4'hF,    -1);

    // Reset while a load waits for its acknowledge
    hold_ack = 1'b1;
    @(posedge clk); #2;
    data_we = 1'b0; data_be = 4'hF; data_addr = 32'h0000_0040; data_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    check("rst_mid_started", 32'(mem_req), 32'h1);
    @(posedge clk); #3;
    rst = 1'b0; data_req = 1'b0;
    #1;
    check("rst_mid_mem_req",    32'(mem_req),    32'h0);
    check("rst_mid_data_ready", 32'(data_ready), 32'h0);
    check("rst_mid_state",      32'(state_dbg),  32'(ST_IDLE));
    @(negedge clk);
    hold_ack = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    directed(1'b0, 1'b0, 4'hF, 32'hA000_0200, 32'h0, 32'h0000_0200, 1'b0, 4'hF, 1);

    // Both sides requesting continuously from a cleared starvation count
    do_reset();
    g_cnt = 0; g_inst = 1'b0; g_active = 1'b1;
    mode = 2;
    repeat (60) @(posedge clk);
    drain();
    g_active = 1'b0;
    check("starve_inst_served", 32'(g_inst), 32'h1);

    mode = 1;
    repeat (800) @(posedge clk);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive data grants with an instruction request pending before one instruction grant is forced.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 inst_req  input  1  instruction fetch request; held high with stable inst_addr until inst_ready.
REQ-005 inst_addr  input  32  instruction virtual address.
REQ-006 inst_rdata  output  32  fetched word; valid only while inst_ready=1.
REQ-007 inst_ready  output  1  one-cycle completion strobe to the fetch side.
REQ-008 data_req  input  1  load/store request; held high with stable data_we/data_be/data_addr/data_wdata until data_ready.
REQ-009 data_we  input  1  1=store, 0=load.
REQ-010 data_be  input  4  byte enables.
REQ-011 data_addr  input  32  data virtual address.
REQ-012 data_wdata  input  32  store data.
REQ-013 data_rdata  output  32  load data; valid only while data_ready=1.
REQ-014 data_ready  output  1  one-cycle completion strobe to the data side.
REQ-015 mem_req  output  1  registered request to the single memory port.
REQ-016 mem_we, mem_be[3:0], mem_addr[31:0], mem_wdata[31:0]  output  registered; stable while mem_req=1.
REQ-017 mem_cached  output  1  0 for kseg1 accesses, 1 otherwise.
REQ-018 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-019 mem_ack  input  1  one-cycle completion from memory; ignored when mem_req=0.

Function
REQ-020 FSM states: IDLE, INST, DATA.
REQ-021 IDLE: data_req only -> DATA; inst_req only -> INST; both -> DATA, unless starve counter == STARVE_LIMIT, then INST; neither -> stay in IDLE.
REQ-022 On leaving IDLE, the selected request's fields are latched into the mem_* registers with the translated address; mem_req=1 from the next cycle.
REQ-023 Translation: 0x0000_0000-0x7FFF_FFFF unchanged; 0x8000_0000-0x9FFF_FFFF minus 0x8000_0000; 0xA000_0000-0xBFFF_FFFF minus 0xA000_0000, mem_cached=0; 0xC000_0000-0xFFFF_FFFF unchanged.
REQ-024 The instruction path latches we=0 and be=4'hF.
REQ-025 INST/DATA: hold mem_* stable until mem_ack; in the mem_ack cycle drive the owner's ready=1 and rdata=mem_rdata combinationally, then clear mem_req and return to IDLE at the next edge.
REQ-026 Both requesters may issue a new request in the cycle after ready; IDLE arbitrates it that cycle, giving back-to-back transactions with mem_req low for exactly one cycle.
REQ-027 ready outputs are 0 outside the mem_ack cycle; the non-owner's ready is never asserted. rdata is 0 when the matching ready=0.
REQ-028 Starve counter (3 bits, saturating at STARVE_LIMIT): increments on a data grant while inst_req=1; clears on any instruction grant.
REQ-029 Stores also complete on mem_ack; data_rdata is don't-care for stores.
REQ-030 Fixed latency: request seen in IDLE at cycle 0 -> mem_req at cycle 1 -> ready in the mem_ack cycle (at least cycle 1).

Reset
REQ-031 rst=0 immediately forces state=IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata=0, mem_cached=1, starve counter=0; ready/rdata outputs=0.
REQ-032 Reset during INST/DATA abandons the transaction without a ready strobe; the memory side tolerates a dropped mem_req.

Structure
REQ-033 State encoding, STARVE_LIMIT default and kseg base constants live in the shared bus/define package; widths use the existing address bus macro.
REQ-034 One combinational sub-module, mem_addr_map (vaddr -> paddr, cached), is instantiated once on the muxed request address.

Verification
REQ-035 data_req load at 0x8000_0010, mem_ack two cycles after mem_req -> mem_addr=0x0000_0010, mem_cached=1, data_ready with mem_rdata in the ack cycle.
REQ-036 inst_req at 0xBFC0_0000 -> mem_addr=0x1FC0_0000, mem_cached=0, mem_be=4'hF, mem_we=0.
REQ-037 inst_req and data_req raised together, data re-requested continuously -> grants D,D,D,D,I,D...; inst_ready after the 4th data completion.
REQ-038 Store at 0x0000_0100 with be=4'b0011 -> mem_we=1, mem_be=4'b0011, mem_addr unchanged; inst_ready never asserted.
REQ-039 rst low while in DATA awaiting mem_ack -> mem_req=0 asynchronously, no data_ready; after release a fresh request completes normally.
